// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite attribute type, background id and colour helper
package sprite_pkg;

  // Coordinate width carried in the attribute record; the compositor's COORD_W defaults to it.
  localparam int ATTR_COORD_W = 10;
  // Background hit id; sized to all-ones at the point of use.
  localparam int BG_ID = -1;

  typedef struct packed {
    logic [ATTR_COORD_W-1:0] x;
    logic [ATTR_COORD_W-1:0] y;
    logic                    en;
    logic                    mirror;
    logic [23:0]             rgb;
  } sprite_attr_t;

  function automatic logic [23:0] rgb555_to_888(input logic [14:0] c);
    return {c[14:10], 3'b000, c[9:5], 3'b000, c[4:0], 3'b000};
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// rtl/sprite_compositor_if.sv - pixel timing in / composited colour out bundle
interface sprite_compositor_if #(
  parameter int COORD_W = 10,
  parameter int ID_W    = 3
) ();
  logic               frame_start;
  logic               pix_valid;
  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic [7:0]         Red;
  logic [7:0]         Green;
  logic [7:0]         Blue;
  logic               out_valid;
  logic [ID_W-1:0]    hit_id;

  modport master (
    output frame_start, pix_valid, DrawX, DrawY,
    input  Red, Green, Blue, out_valid, hit_id
  );

  modport slave (
    input  frame_start, pix_valid, DrawX, DrawY,
    output Red, Green, Blue, out_valid, hit_id
  );
endinterface

// File: rtl/sprite_channel.sv
// rtl/sprite_channel.sv - one sprite: frame shadow, hit test, ROM row address, bitmap bit select
module sprite_channel
  import sprite_pkg::*;
#(
  parameter int SPR_SIZE = 100,
  parameter int COORD_W  = ATTR_COORD_W,
  parameter int ROW_W    = 7
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_start,
  input  logic                pix_valid,
  input  logic [COORD_W-1:0]  DrawX,
  input  logic [COORD_W-1:0]  DrawY,
  input  sprite_attr_t        live,
  input  logic [SPR_SIZE-1:0] rom_data,
  output logic [ROW_W-1:0]    rom_row,
  output logic                opq,
  output logic [23:0]         rgb
);

  sprite_attr_t shadow;
  sprite_attr_t cur;

  // A pixel arriving together with frame_start already belongs to the new frame.
  assign cur = frame_start ? live : shadow;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow <= '0;
    end else if (frame_start) begin
      shadow <= live;
    end
  end

  // One extra bit so x+SPR_SIZE past the right edge cannot wrap onto column 0.
  logic [COORD_W:0] px, py, x0, y0, span;
  logic             in_s0;
  logic [ROW_W-1:0] col_s0;

  assign px   = {1'b0, DrawX};
  assign py   = {1'b0, DrawY};
  assign x0   = {1'b0, cur.x};
  assign y0   = {1'b0, cur.y};
  assign span = (COORD_W+1)'(SPR_SIZE);

  assign in_s0   = cur.en && (px >= x0) && (px < x0 + span) && (py >= y0) && (py < y0 + span);
  assign col_s0  = ROW_W'(DrawX - cur.x);
  assign rom_row = in_s0 ? ROW_W'(DrawY - cur.y) : '0;

  logic             in_s1;
  logic [ROW_W-1:0] col_s1;
  logic [ROW_W-1:0] sel;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_s1  <= 1'b0;
      col_s1 <= '0;
    end else begin
      in_s1  <= in_s0 & pix_valid;
      col_s1 <= col_s0;
    end
  end

  // The shadow only changes on the edge that ends a frame_start cycle, so an S1 pixel
  // still sees the mirror/colour of the frame it was hit-tested in.
  assign sel = shadow.mirror ? ROW_W'(SPR_SIZE-1) - col_s1 : col_s1;
  assign opq = in_s1 & ~rom_data[sel];
  assign rgb = shadow.rgb;

endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - N-channel priority sprite compositor with per-frame collision flags
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_SPR  = 4,
  parameter int SPR_SIZE = 100,
  parameter int COORD_W  = ATTR_COORD_W,
  parameter int ROW_W    = 7
) (
  input  logic                               Clk,
  input  logic                               Reset_n,
  sprite_compositor_if.slave                 pix,
  input  logic [NUM_SPR-1:0][COORD_W-1:0]    spr_x,
  input  logic [NUM_SPR-1:0][COORD_W-1:0]    spr_y,
  input  logic [NUM_SPR-1:0]                 spr_en,
  input  logic [NUM_SPR-1:0]                 spr_mirror,
  input  logic [NUM_SPR-1:0][23:0]           spr_rgb,
  output logic [NUM_SPR-1:0][ROW_W-1:0]      rom_row,
  input  logic [NUM_SPR-1:0][SPR_SIZE-1:0]   rom_data,
  input  logic [14:0]                        bg_data,
  output logic [NUM_SPR-1:0]                 collision
);

  localparam int ID_W = $clog2(NUM_SPR) + 1;
  localparam logic [ID_W-1:0] HIT_BG = ID_W'(BG_ID);

  logic [NUM_SPR-1:0]       opq;
  logic [NUM_SPR-1:0][23:0] ch_rgb;

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_ch
    sprite_attr_t live;
    assign live = '{x: spr_x[i], y: spr_y[i], en: spr_en[i], mirror: spr_mirror[i], rgb: spr_rgb[i]};

    sprite_channel #(
      .SPR_SIZE (SPR_SIZE),
      .COORD_W  (COORD_W),
      .ROW_W    (ROW_W)
    ) u_ch (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .frame_start (pix.frame_start),
      .pix_valid   (pix.pix_valid),
      .DrawX       (pix.DrawX),
      .DrawY       (pix.DrawY),
      .live        (live),
      .rom_data    (rom_data[i]),
      .rom_row     (rom_row[i]),
      .opq         (opq[i]),
      .rgb         (ch_rgb[i])
    );
  end

  logic              valid_s1;
  logic [ID_W-1:0]   win_id;
  logic [23:0]       win_rgb;
  logic [NUM_SPR-1:0] acc, acc_next, others;

  // Walk from lowest priority up so the lowest opaque index wins.
  always_comb begin
    win_id  = HIT_BG;
    win_rgb = rgb555_to_888(bg_data);
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (opq[i]) begin
        win_id  = ID_W'(i);
        win_rgb = ch_rgb[i];
      end
    end
  end

  always_comb begin
    acc_next = acc;
    others   = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      others    = opq;
      others[i] = 1'b0;
      if (valid_s1 && opq[i] && (|others)) begin
        acc_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_s1                          <= 1'b0;
      pix.out_valid                     <= 1'b0;
      {pix.Red, pix.Green, pix.Blue}    <= '0;
      pix.hit_id                        <= HIT_BG;
      acc                               <= '0;
      collision                         <= '0;
    end else begin
      valid_s1      <= pix.pix_valid;
      pix.out_valid <= valid_s1;
      if (valid_s1) begin
        {pix.Red, pix.Green, pix.Blue} <= win_rgb;
        pix.hit_id                     <= win_id;
      end else begin
        {pix.Red, pix.Green, pix.Blue} <= '0;
        pix.hit_id                     <= HIT_BG;
      end
      // Publishing uses acc_next so an overlap on the frame's last pixel is not lost.
      if (pix.frame_start) begin
        collision <= acc_next;
        acc       <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end

endmodule
